// File: rtl/rr_mux_reg.sv
// rr_mux_reg: N-channel, W-bit valid/ready multiplexer with a registered
// output stage. Channel selection is round-robin (rr_en=1) or fixed
// priority with channel 0 highest (rr_en=0).
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   rr_en      1 = round-robin arbitration, 0 = fixed priority
//   in_valid   per-channel data valid            [N_CH]
//   in_data    packed channel data, ch i at [i*W +: W]
//   in_ready   per-channel accept, one-hot or zero [N_CH]
//   out_valid  output register holds a valid word
//   out_data   registered selected data          [W]
//   out_ch     channel that supplied out_data    [CH_W]
//   out_ready  downstream accepts the current word
module rr_mux_reg #(
  parameter int N_CH = 4,
  parameter int W    = 8,
  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rr_en,
  input  logic [N_CH-1:0]   in_valid,
  input  logic [N_CH*W-1:0] in_data,
  output logic [N_CH-1:0]   in_ready,
  output logic              out_valid,
  output logic [W-1:0]      out_data,
  output logic [CH_W-1:0]   out_ch,
  input  logic              out_ready
);

  localparam logic [CH_W-1:0] LAST_CH = CH_W'(N_CH - 1);

  logic [CH_W-1:0] ptr;
  logic            vld_p1;
  logic [W-1:0]    data_p1;
  logic [CH_W-1:0] ch_p1;

  logic            gnt_found_p0;
  logic [CH_W-1:0] gnt_idx_p0;
  logic            load_p0;
  logic            xfer_p0;
  logic [W-1:0]    data_p0;

  // Wrap-around increment that never reaches N_CH..2^CH_W-1, so
  // non-power-of-two channel counts keep ptr in range.
  function automatic logic [CH_W-1:0] next_ptr(input logic [CH_W-1:0] idx);
    next_ptr = (idx == LAST_CH) ? '0 : idx + CH_W'(1);
  endfunction

  // Stage p0: combinational arbitration. The scan starts at ptr in
  // round-robin mode and at channel 0 in fixed-priority mode; the first
  // valid channel found wins.
  always_comb begin
    int idx;
    gnt_found_p0 = 1'b0;
    gnt_idx_p0   = '0;
    for (int k = 0; k < N_CH; k++) begin
      idx = rr_en ? int'(ptr) + k : k;
      if (idx >= N_CH) idx = idx - N_CH;
      if (!gnt_found_p0 && in_valid[idx]) begin
        gnt_found_p0 = 1'b1;
        gnt_idx_p0   = CH_W'(idx);
      end
    end
  end

  assign load_p0 = !vld_p1 || out_ready;
  assign xfer_p0 = rst_n && load_p0 && gnt_found_p0;
  assign data_p0 = in_data[int'(gnt_idx_p0)*W +: W];

  // in_ready is forced low while reset is held so no source sees an accept.
  always_comb begin
    in_ready = '0;
    if (xfer_p0) in_ready[gnt_idx_p0] = 1'b1;
  end

  // Stage p1: output register. A drained word keeps its data/channel; only
  // the valid flag drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      ch_p1   <= '0;
      ptr     <= '0;
    end else begin
      if (xfer_p0) begin
        vld_p1  <= 1'b1;
        data_p1 <= data_p0;
        ch_p1   <= gnt_idx_p0;
        if (rr_en) ptr <= next_ptr(gnt_idx_p0);
      end else if (out_ready) begin
        vld_p1 <= 1'b0;
      end
    end
  end

  assign out_valid = vld_p1;
  assign out_data  = data_p1;
  assign out_ch    = ch_p1;

endmodule

// File: tb/tb_rr_mux_reg.sv
// Testbench for rr_mux_reg (N_CH=4, W=8): directed scenarios followed by a
// randomized run, all checked against a behavioural model.
module tb_rr_mux_reg;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        rr_en = 1'b1;
  logic [3:0]  in_valid = '0;
  logic [31:0] in_data = '0;
  logic [3:0]  in_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic [1:0]  out_ch;
  logic        out_ready = 1'b0;

  int ntests = 0;
  int nfail  = 0;

  // Model state
  int       m_ptr  = 0;
  bit       m_vld  = 0;
  int       m_data = 0;
  int       m_ch   = 0;

  rr_mux_reg #(.N_CH(4), .W(8)) dut (
    .clk(clk), .rst_n(rst_n), .rr_en(rr_en),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ch(out_ch),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Channel the spec's rules would grant, or -1 when nothing is valid.
  function automatic int model_grant();
    int start;
    start = rr_en ? m_ptr : 0;
    for (int k = 0; k < 4; k++)
      if (in_valid[(start + k) % 4]) return (start + k) % 4;
    return -1;
  endfunction

  function automatic void model_reset();
    m_ptr = 0; m_vld = 0; m_data = 0; m_ch = 0;
  endfunction

  // One clock: check in_ready on the falling edge, advance the model at the
  // rising edge, check the output register just after it.
  task automatic tick(input string tag);
    int g;
    bit load;
    int exp_rdy;
    @(negedge clk);
    g = model_grant();
    load = !m_vld || out_ready;
    exp_rdy = (load && g >= 0) ? (1 << g) : 0;
    chk({tag, ".in_ready"}, int'(in_ready), exp_rdy);
    @(posedge clk);
    if (exp_rdy != 0) begin
      m_vld  = 1;
      m_data = int'(in_data[g*8 +: 8]);
      m_ch   = g;
      if (rr_en) m_ptr = (g + 1) % 4;
    end else if (m_vld && out_ready) begin
      m_vld = 0;
    end
    #1;
    chk({tag, ".out_valid"}, int'(out_valid), int'(m_vld));
    chk({tag, ".out_data"},  int'(out_data),  m_data);
    chk({tag, ".out_ch"},    int'(out_ch),    m_ch);
  endtask

  initial begin
    int exp_rr [5];
    int exp_wrap [3];
    exp_rr   = '{0, 1, 2, 3, 0};
    exp_wrap = '{0, 2, 0};

    // Reset: with inputs that would otherwise be accepted.
    in_valid = 4'b1111; out_ready = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    chk("rst.out_valid", int'(out_valid), 0);
    chk("rst.out_data",  int'(out_data),  0);
    chk("rst.out_ch",    int'(out_ch),    0);
    chk("rst.in_ready",  int'(in_ready),  0);
    rst_n = 1'b1;

    // Round-robin fairness.
    rr_en = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
    in_data = {8'h43, 8'h32, 8'h21, 8'h10};
    for (int i = 0; i < 5; i++) begin
      tick("rr");
      chk("rr.seq_ch", int'(out_ch), exp_rr[i]);
    end

    // Fixed priority: channel 1 wins over 3 every cycle.
    rr_en = 1'b0; in_valid = 4'b1010;
    for (int i = 0; i < 3; i++) begin
      tick("fp");
      chk("fp.ch1", int'(out_ch), 1);
    end

    // Backpressure: hold A5 while out_ready is low.
    in_valid = 4'b0100; in_data = {8'h00, 8'hA5, 8'h00, 8'h00};
    tick("bp_load");
    out_ready = 1'b0; in_valid = 4'b0001; in_data = {8'h00, 8'hA5, 8'h00, 8'h5A};
    for (int i = 0; i < 3; i++) begin
      tick("bp_hold");
      chk("bp.data_a5", int'(out_data), 8'hA5);
    end
    out_ready = 1'b1;
    tick("bp_release");
    chk("bp.new_word", int'(out_data), 8'h5A);
    chk("bp.valid", int'(out_valid), 1);

    // Pointer wrap and skip: drive ptr to 3, then alternate 0 and 2.
    rr_en = 1'b1; in_valid = 4'b0100; in_data = {8'h33, 8'h22, 8'h11, 8'h00};
    tick("wrap_setup");
    in_valid = 4'b0101;
    for (int i = 0; i < 3; i++) begin
      tick("wrap");
      chk("wrap.seq_ch", int'(out_ch), exp_wrap[i]);
    end

    // Idle drain.
    in_valid = 4'b0010; in_data = {8'h00, 8'h00, 8'h77, 8'h00};
    tick("drain_load");
    in_valid = 4'b0000;
    for (int i = 0; i < 2; i++) tick("drain");
    chk("drain.hold", int'(out_data), 8'h77);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      rr_en     = ($urandom_range(0, 7) != 0);
      in_valid  = 4'($urandom);
      in_data   = $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
      tick("rand");
    end

    // Reset asserted mid-cycle while a word is held.
    in_valid = 4'b1000; in_data = 32'hC3000000; out_ready = 1'b1;
    tick("mid_load");
    out_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("mid.out_valid", int'(out_valid), 0);
    chk("mid.out_data",  int'(out_data),  0);
    chk("mid.out_ch",    int'(out_ch),    0);
    out_ready = 1'b1;
    #1;
    chk("mid.in_ready",  int'(in_ready),  0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    in_valid = 4'b0110; in_data = {8'h00, 8'h66, 8'h55, 8'h00};
    for (int i = 0; i < 3; i++) tick("post_rst");

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

// File: doc/rr_mux_reg.md
Name: rr_mux_reg

Overview:
- Parametrised N-channel, W-bit multiplexer; successor to the single-bit 2:1 mux primitive.
- Adds per-channel valid/ready handshakes, round-robin or fixed-priority channel selection, and a registered output stage.
- Used as the merge point where several producers share one downstream consumer, e.g. a shared display/UART/LED path in lab designs.

Parameters:
- N_CH, 4, number of input channels (2..16).
- W, 8, data width per channel in bits (>=1).
- CH_W, $clog2(N_CH) (minimum 1), width of the channel-id output; derived, not overridden.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- rr_en  input  1  1 = round-robin arbitration; 0 = fixed priority, channel 0 highest.
- in_valid  input  N_CH  per-channel data-valid.
- in_data  input  N_CH*W  packed channel data; channel i occupies bits [i*W +: W].
- in_ready  output  N_CH  per-channel accept, one-hot or zero.
- out_valid  output  1  output register holds a valid word.
- out_data  output  W  registered selected data.
- out_ch  output  CH_W  index of the channel that supplied out_data.
- out_ready  input  1  downstream accepts the current output word.

Behaviour:
- Reset (rst_n=0, asynchronous assert; release synchronous to clk by the integrator):
  - out_valid=0, out_data=0, out_ch=0.
  - Round-robin pointer ptr=0.
  - in_ready=0 while reset is asserted.
- Load condition: load = !out_valid || out_ready. The output register may take a new word in the cycle load=1.
- Grant selection (combinational):
  - rr_en=1: grant the first channel i with in_valid[i]=1, scanning ptr, ptr+1, ..., wrapping modulo N_CH.
  - rr_en=0: grant the lowest-index channel with in_valid=1.
  - No in_valid bit set means no grant.
- in_ready[i] = load && grant[i]. At most one bit is high. in_ready is combinational from out_ready, out_valid and in_valid; there is no skid buffer.
- Input transfer:
  - Occurs when in_valid[i] && in_ready[i] at the clock edge.
  - On that edge: out_data <= channel i data, out_ch <= i, out_valid <= 1.
- Output transfer: occurs when out_valid && out_ready.
  - If a new input transfer happens in the same cycle, the register is overwritten with the new word and out_valid stays 1.
  - Otherwise out_valid <= 0.
  - out_data and out_ch hold their last value while out_valid=0.
- Latency: one cycle from input transfer to the word appearing on out_*. With out_ready held at 1, throughput is one word per cycle.
- Backpressure: with out_valid=1 and out_ready=0, all in_ready=0 and out_valid/out_data/out_ch stay stable.
- ptr update:
  - Only on an input transfer and only when rr_en=1: ptr <= (granted+1) mod N_CH, wrapping from N_CH-1 to 0.
  - When rr_en=0, ptr is unchanged.
  - Toggling rr_en takes effect on the next grant computation; no flush.
- Sources must hold in_valid and in_data stable until accepted. The block does not check this; a deasserted in_valid simply drops the channel from arbitration.
- Reset asserted mid-transfer: any word in the output register is discarded, and state returns to the reset values above.
- N_CH not a power of two: ptr wraps at N_CH and never takes the values N_CH..2^CH_W-1.

Test Plan:
- Reset values (N_CH=4, W=8): assert rst_n=0 mid-cycle with out_valid=1 -> out_valid=0, out_data=0, out_ch=0 immediately, without waiting for a clock edge; in_ready=0.
- Round-robin fairness: rr_en=1, all four channels valid with data 8'h10,8'h21,8'h32,8'h43, out_ready=1 -> out_ch sequence 0,1,2,3,0 on consecutive cycles; out_data 10,21,32,43,10; one word per cycle.
- Fixed priority: rr_en=0, in_valid=4'b1010 held, out_ready=1 -> out_ch=1 every cycle; in_ready=4'b0010; channel 3 never granted.
- Backpressure: out_valid=1 with data 8'hA5, out_ready=0 for 3 cycles -> out_data=A5 stable and in_ready=0 throughout; out_ready=1 with new data waiting -> the new word loads in the same cycle and out_valid stays 1.
- Pointer wrap and skip: rr_en=1, ptr=3, in_valid=4'b0101 -> grant channel 0, then ptr=1 -> grant channel 2, then ptr=3 -> grant channel 0.
- Idle drain: a single word is accepted, then in_valid=0 and out_ready=1 -> out_valid=1 for exactly one cycle, then 0; out_data holds its last value.
